// File: rtl/seq_display.sv
// seq_display: plays back a stored sequence of colours on four one-hot LEDs.
//
// A 16-entry, 2-bit colour memory is filled from a free-running 8-bit
// Fibonacci LFSR on new_game. On start the block clears an external sequence
// counter, then for each step lights the colour addressed by seq_idx for
// ON_CYC cycles and keeps the LEDs dark for OFF_CYC cycles. It then samples
// the counter's terminal count during a one-cycle STEP state. After the last
// step it pulses done for one cycle and returns to IDLE.
//
// Counter pulse protocol: cnt_rst is a one-cycle, active-high synchronous
// clear that is high only while in CLR. cnt_en is a one-cycle increment
// request that is high only on the last OFF cycle of each step. The two are
// never high together. The counter has therefore already advanced when STEP
// samples tc and seq_idx. Every output is a register, updated in the same
// clock edge that moves the FSM into the state the output belongs to.
//
// dbg_state exposes the current FSM state encoding.

module seq_display #(
   parameter int         ON_CYC    = 8,
   parameter int         OFF_CYC   = 4,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       R_n,
   input  logic       new_game,
   input  logic       start,
   input  logic [3:0] seq_idx,
   input  logic       tc,
   output logic       cnt_rst,
   output logic       cnt_en,
   output logic [3:0] leds,
   output logic       busy,
   output logic       done,
   output logic [2:0] dbg_state
);

   // The duration counter must span the longest state: ON, OFF or the
   // 16-cycle FILL.
   localparam int MAX_ON_OFF = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int MAXC       = (MAX_ON_OFF > 16) ? MAX_ON_OFF : 16;
   localparam int CW         = $clog2(MAXC);

   // Terminal values of the duration counter, one per timed state.
   localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYC - 1);
   localparam logic [CW-1:0] OFF_LAST  = CW'(OFF_CYC - 1);
   localparam logic [CW-1:0] FILL_LAST = CW'(15);

   // Value of the counter one cycle before the last OFF cycle. This value is
   // only consulted when OFF lasts at least two cycles.
   localparam logic [CW-1:0] OFF_PRE = CW'((OFF_CYC > 1) ? (OFF_CYC - 2) : 0);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FILL = 3'd1,
      S_CLR  = 3'd2,
      S_ON   = 3'd3,
      S_OFF  = 3'd4,
      S_STEP = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t        state;
   logic [CW-1:0] dur;
   logic [7:0]    lfsr;
   logic [1:0]    mem [16];

   assign dbg_state = state;

   // One-hot LED pattern for a 2-bit colour code.
   function automatic logic [3:0] colour(input logic [1:0] c);
      return 4'b0001 << c;
   endfunction

   // Free-running LFSR with taps at bits 7, 5, 4 and 3; it never stops, so
   // the fill contents depend on when new_game arrives.
   always_ff @(posedge clk or negedge R_n) begin
      if (!R_n) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   // Colour memory: cleared on reset, one entry written per FILL cycle.
   always_ff @(posedge clk or negedge R_n) begin
      if (!R_n) begin
         for (int i = 0; i < 16; i++) begin
            mem[i] <= 2'b00;
         end
      end else if (state == S_FILL) begin
         mem[dur[3:0]] <= lfsr[1:0];
      end
   end

   // Playback FSM with registered outputs; the pulse outputs default low.
   always_ff @(posedge clk or negedge R_n) begin
      if (!R_n) begin
         state   <= S_IDLE;
         dur     <= '0;
         cnt_rst <= 1'b0;
         cnt_en  <= 1'b0;
         leds    <= 4'b0000;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         cnt_rst <= 1'b0;
         cnt_en  <= 1'b0;
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               leds <= 4'b0000;
               if (new_game) begin
                  state <= S_FILL;
                  dur   <= '0;
                  busy  <= 1'b1;
               end else if (start) begin
                  state   <= S_CLR;
                  cnt_rst <= 1'b1;
                  busy    <= 1'b1;
               end
            end

            S_FILL: begin
               if (dur == FILL_LAST) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  dur <= dur + 1'b1;
               end
            end

            // The counter clears on this edge, so the first step shows entry 0.
            S_CLR: begin
               state <= S_ON;
               dur   <= '0;
               leds  <= colour(mem[4'd0]);
            end

            S_ON: begin
               if (dur == ON_LAST) begin
                  state  <= S_OFF;
                  dur    <= '0;
                  leds   <= 4'b0000;
                  cnt_en <= (OFF_CYC == 1);
               end else begin
                  dur <= dur + 1'b1;
               end
            end

            S_OFF: begin
               if (dur == OFF_LAST) begin
                  state <= S_STEP;
               end else begin
                  dur    <= dur + 1'b1;
                  cnt_en <= (dur == OFF_PRE);
               end
            end

            // The counter has advanced by now, so tc and seq_idx refer to
            // the next step.
            S_STEP: begin
               if (tc) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  state <= S_ON;
                  dur   <= '0;
                  leds  <= colour(mem[seq_idx]);
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
               leds  <= 4'b0000;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_display.sv
// Testbench for seq_display. A behavioural sequence counter drives seq_idx
// and tc, a reference LFSR predicts the fill contents, and a per-cycle
// expected-output queue checks the complete output stream of every round.
`timescale 1ns/1ps

module tb_seq_display;

   localparam int ON_CYC  = 8;
   localparam int OFF_CYC = 4;
   localparam int PER     = ON_CYC + OFF_CYC + 1;

   logic       clk = 1'b0;
   logic       R_n = 1'b1;
   logic       new_game = 1'b0;
   logic       start = 1'b0;
   logic [3:0] seq_idx;
   logic       tc;
   logic       cnt_rst, cnt_en, busy, done;
   logic [3:0] leds;
   logic [2:0] dbg_state;

   // clock and reset
   always #5 clk = ~clk;

   seq_display #(
      .ON_CYC   (ON_CYC),
      .OFF_CYC  (OFF_CYC),
      .LFSR_SEED(8'hA5)
   ) dut (
      .clk      (clk),
      .R_n      (R_n),
      .new_game (new_game),
      .start    (start),
      .seq_idx  (seq_idx),
      .tc       (tc),
      .cnt_rst  (cnt_rst),
      .cnt_en   (cnt_en),
      .leds     (leds),
      .busy     (busy),
      .done     (done),
      .dbg_state(dbg_state)
   );

   // neighbouring sequence counter: tc goes high once 'cnt_data+1' steps are done
   logic [4:0] steps = 5'd0;
   int         cnt_data = 0;
   always @(posedge clk) begin
      if (cnt_rst) steps <= 5'd0;
      else if (cnt_en) steps <= steps + 5'd1;
   end
   assign seq_idx = steps[3:0];
   assign tc      = (int'(steps) > cnt_data);

   // reference LFSR
   logic [7:0] ref_lfsr;
   always @(posedge clk or negedge R_n) begin
      if (!R_n) ref_lfsr <= 8'hA5;
      else ref_lfsr <= {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
   end

   // scoreboard: {cnt_rst, cnt_en, busy, done, leds[3:0]}
   logic [7:0] exp_q[$];
   logic [1:0] exp_mem[16];
   int         n_pass  = 0;
   int         n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push_exp(input logic r, input logic e, input logic b, input logic d,
                           input logic [3:0] l);
      exp_q.push_back({r, e, b, d, l});
   endtask

   task automatic check_cycle(input string name);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         n_total++;
         $display("FAIL %s: scoreboard queue empty, got %0h", name,
                  {cnt_rst, cnt_en, busy, done, leds});
      end else begin
         e = exp_q.pop_front();
         check(name, {24'd0, cnt_rst, cnt_en, busy, done, leds}, {24'd0, e});
      end
   endtask

   // expected stream of a round of n steps: CLR, steps, DONE, one idle cycle
   task automatic build_round(input int n);
      push_exp(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
      for (int k = 0; k < n; k++) begin
         for (int c = 0; c < ON_CYC; c++) push_exp(1'b0, 1'b0, 1'b1, 1'b0, 4'b0001 << exp_mem[k]);
         for (int c = 0; c < OFF_CYC; c++) push_exp(1'b0, c == OFF_CYC - 1, 1'b1, 1'b0, 4'b0000);
         push_exp(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
      end
      push_exp(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
      push_exp(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
   endtask

   // driver: play one round; 'poke' raises start and new_game during ON phases
   task automatic play_round(input int data, input bit poke, output int en_seen,
                             output int done_off);
      int n;
      int len;
      n        = data + 1;
      len      = PER * n + 3;
      cnt_data = data;
      en_seen  = 0;
      done_off = -1;
      build_round(n);
      @(negedge clk);
      start = 1'b1;
      for (int c = 0; c < len; c++) begin
         @(posedge clk);
         #1;
         start    = 1'b0;
         new_game = 1'b0;
         check_cycle($sformatf("round_d%0d_cyc%0d", data, c));
         if (cnt_en) en_seen++;
         if (done) done_off = c;
         if (poke && (c == 3 || c == 14)) begin
            start    = 1'b1;
            new_game = 1'b1;
         end
      end
   endtask

   // driver: fill the memory, recording the reference LFSR colour per fill cycle
   task automatic do_fill(input bit both);
      for (int i = 0; i < 16; i++) push_exp(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
      push_exp(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      @(negedge clk);
      new_game = 1'b1;
      start    = both;
      for (int c = 0; c < 17; c++) begin
         @(posedge clk);
         #1;
         new_game = 1'b0;
         start    = 1'b0;
         if (c < 16) exp_mem[c] = ref_lfsr[1:0];
         check_cycle($sformatf("fill_both%0d_cyc%0d", both, c));
      end
   endtask

   // driver: asynchronous reset, checked while held, released on a falling edge
   task automatic do_reset(input string name);
      R_n = 1'b0;
      #1;
      check({name, "_outputs"}, {24'd0, cnt_rst, cnt_en, busy, done, leds}, 32'd0);
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_mem[i] = 2'b00;
      @(negedge clk);
      R_n = 1'b1;
   endtask

   typedef struct {
      bit fill;
      bit both;
      int data;
      bit poke;
      int exp_en;
      int exp_done;
   } vec_t;

   vec_t vecs[5];
   int   en_seen;
   int   done_off;

   // watchdog
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
      $fatal(1);
   end

   initial begin
      vecs[0] = '{fill: 1'b0, both: 1'b0, data: 2,  poke: 1'b0, exp_en: 3,  exp_done: 40};
      vecs[1] = '{fill: 1'b0, both: 1'b0, data: 0,  poke: 1'b0, exp_en: 1,  exp_done: 14};
      vecs[2] = '{fill: 1'b1, both: 1'b0, data: 15, poke: 1'b0, exp_en: 16, exp_done: 209};
      vecs[3] = '{fill: 1'b1, both: 1'b1, data: 5,  poke: 1'b1, exp_en: 6,  exp_done: 79};
      vecs[4] = '{fill: 1'b0, both: 1'b0, data: 7,  poke: 1'b1, exp_en: 8,  exp_done: 105};

      // power-on reset
      #2;
      R_n = 1'b0;
      #1;
      check("por_outputs", {24'd0, cnt_rst, cnt_en, busy, done, leds}, 32'd0);
      check("por_state", {29'd0, dbg_state}, 32'd0);
      for (int i = 0; i < 16; i++) exp_mem[i] = 2'b00;
      repeat (2) @(negedge clk);
      R_n = 1'b1;

      // table-driven rounds
      for (int v = 0; v < 5; v++) begin
         if (vecs[v].fill) do_fill(vecs[v].both);
         play_round(vecs[v].data, vecs[v].poke, en_seen, done_off);
         check($sformatf("vec%0d_en_count", v), en_seen, vecs[v].exp_en);
         check($sformatf("vec%0d_done_offset", v), done_off, vecs[v].exp_done);
      end

      // reset during OFF of step 2, then replay from step 0
      cnt_data = 3;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (36) @(posedge clk);
      #1;
      check("midoff_busy", busy, 1'b1);
      check("midoff_leds", leds, 4'b0000);
      do_reset("midoff_reset");
      for (int c = 0; c < 3; c++) push_exp(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check_cycle($sformatf("post_reset_idle_cyc%0d", c));
      end
      play_round(3, 1'b0, en_seen, done_off);
      check("replay_en_count", en_seen, 4);
      check("replay_done_offset", done_off, 53);

      // new_game one cycle after reset
      @(posedge clk);
      #1;
      do_reset("prefill_reset");
      do_fill(1'b0);
      play_round(4, 1'b0, en_seen, done_off);
      check("postfill_en_count", en_seen, 5);
      check("postfill_done_offset", done_off, 66);

      // reset in the middle of FILL discards the partial fill
      @(negedge clk);
      new_game = 1'b1;
      @(posedge clk);
      #1;
      new_game = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("midfill_busy", busy, 1'b1);
      do_reset("midfill_reset");
      play_round(1, 1'b0, en_seen, done_off);
      check("midfill_replay_en_count", en_seen, 2);
      check("midfill_replay_done_offset", done_off, 27);

      check("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
